// File: rtl/stack_seq_ctrl_if.sv
// stack_seq_ctrl_if: 16-bit data-memory port shared by the load/store path and the stack sequencer.
interface stack_seq_ctrl_if;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] rd_data;

    modport master (output mem_addr, mem_wdata, mem_read, mem_write, input rd_data);
    modport slave  (input mem_addr, mem_wdata, mem_read, mem_write, output rd_data);
endinterface

// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: multi-cycle CALL/RET/INT/RTI/PUSH/POP sequencer owning the data-memory port; optional SP bound check under STACK_BOUND_CHECK_EN.
module stack_seq_ctrl #(
    parameter logic [31:0] SP_RESET = 32'd2047,
    parameter int          DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op_type,
    input  logic [31:0]       pc_in,
    input  logic [3:0]        flags_in,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ls_read,
    input  logic              ls_write,
    input  logic [31:0]       ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    stack_seq_ctrl_if.master  mem,
    output logic [31:0]       sp_out,
    output logic              stall,
    output logic              done,
    output logic              pc_load,
    output logic [31:0]       pc_load_val,
    output logic              flags_load,
    output logic [3:0]        flags_load_val,
    output logic [DATA_W-1:0] pop_data,
    output logic              sp_fault
);
    localparam logic [2:0] OP_CALL = 3'd1, OP_RET = 3'd2, OP_INT = 3'd3,
                           OP_RTI = 3'd4, OP_PUSH = 3'd5;

    typedef enum logic [3:0] {
        IDLE, PUSH_LO, PUSH_HI, PUSH_FL, POP_FL, POP_HI, POP_LO, PUSH_W, POP_W
    } state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_sp, r_pc;
    logic [15:0]       r_temp;
    logic [3:0]        r_flags;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_pdata;
    logic              w_accept, w_push, w_pop, w_fault;

    assign w_accept = reset && r_state == IDLE && op_valid && op_type != 3'd0 && op_type != 3'd7;
    assign w_push   = r_state inside {PUSH_LO, PUSH_HI, PUSH_FL, PUSH_W};
    assign w_pop    = r_state inside {POP_FL, POP_HI, POP_LO, POP_W};
    assign stall    = r_state != IDLE || w_accept;
    assign sp_out   = r_sp;
    assign sp_fault = w_fault;

`ifdef STACK_BOUND_CHECK_EN
    assign w_fault = (w_push && r_sp == 32'd0) || (w_pop && r_sp == SP_RESET);
`else
    assign w_fault = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Stack pointer, latched operation and popped high word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp    <= SP_RESET;
            r_pc    <= 32'd0;
            r_temp  <= 16'd0;
            r_flags <= 4'd0;
            r_op    <= 3'd0;
            r_pdata <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op_type;
                r_pc    <= op_type == OP_INT ? pc_in - 32'd1 : pc_in;
                r_flags <= flags_in;
                r_pdata <= push_data;
            end
            if (w_push && !w_fault) r_sp <= r_sp - 32'd1;
            if (w_pop && !w_fault)  r_sp <= r_sp + 32'd1;
            if (r_state == POP_HI && !w_fault) r_temp <= mem.rd_data;
        end
    end

    // Next-state selection; a bound fault aborts straight back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (op_type == OP_CALL || op_type == OP_INT) ? PUSH_LO :
                                            op_type == OP_RET  ? POP_HI :
                                            op_type == OP_RTI  ? POP_FL :
                                            op_type == OP_PUSH ? PUSH_W : POP_W;
            PUSH_LO: w_next = PUSH_HI;
            PUSH_HI: w_next = r_op == OP_INT ? PUSH_FL : IDLE;
            POP_FL:  w_next = POP_HI;
            POP_HI:  w_next = POP_LO;
            default: w_next = IDLE;
        endcase
        if (w_fault) w_next = IDLE;
    end

    // Memory port drive and completion pulses; IDLE passes the load/store path through
    always_comb begin
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 16'd0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        if (r_state == IDLE) begin
            if (reset) begin
                mem.mem_addr  = ls_addr;
                mem.mem_wdata = ls_wdata;
                mem.mem_read  = ls_read;
                mem.mem_write = ls_write;
            end
        end else begin
            mem.mem_addr  = w_push ? r_sp : r_sp + 32'd1;
            mem.mem_read  = w_pop && !w_fault;
            mem.mem_write = w_push && !w_fault;
        end
        case (r_state)
            PUSH_LO: mem.mem_wdata = r_pc[15:0];
            PUSH_HI: mem.mem_wdata = r_pc[31:16];
            PUSH_FL: mem.mem_wdata = {r_flags, 12'd0};
            PUSH_W:  mem.mem_wdata = r_pdata;
            default: ;
        endcase
        done           = w_fault || (r_state == PUSH_HI && r_op != OP_INT) ||
                         r_state inside {PUSH_FL, POP_LO, PUSH_W, POP_W};
        flags_load     = r_state == POP_FL && !w_fault;
        flags_load_val = flags_load ? mem.rd_data[15:12] : 4'd0;
        pc_load        = r_state == POP_LO && !w_fault;
        pc_load_val    = pc_load ? {r_temp, mem.rd_data} : 32'd0;
        pop_data       = (r_state == POP_W && !w_fault) ? mem.rd_data : '0;
    end
endmodule
